msa_scheduler: RTL and testbench

//  Round-robin scheduler sharing one msa_compressor among NUM_REQ hashing lanes. Accepts one job
//  (64-word schedule w + ShaContext) from a granted lane, buffers it, issues w and ctx to the

---
 rtl/msa_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_msa_scheduler.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msa_scheduler.sv
// ============================================================================
// Module   : msa_scheduler
// Purpose  : Round-robin arbiter that buffers one hashing job at a time. It
//            issues the job to a shared msa_compressor and returns the result
//            context to the lane that owns the job.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module msa_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_vld,
  output logic [NUM_REQ-1:0]                  req_rdy,
  input  logic [NUM_REQ-1:0][63:0][31:0]      req_w,
  input  logic [NUM_REQ-1:0][7:0][31:0]       req_ctx,
  output logic [NUM_REQ-1:0]                  rsp_vld,
  input  logic [NUM_REQ-1:0]                  rsp_rdy,
  output logic [7:0][31:0]                    rsp_ctx,
  output logic                                cmp_w_vld,
  input  logic                                cmp_w_rdy,
  output logic [63:0][31:0]                   cmp_w,
  output logic                                cmp_ctx_vld,
  input  logic                                cmp_ctx_rdy,
  output logic [7:0][31:0]                    cmp_ctx,
  input  logic                                cmp_out_vld,
  output logic                                cmp_out_rdy,
  input  logic [7:0][31:0]                    cmp_out_ctx,
  output logic                                busy,
  output logic [$clog2(NUM_REQ)-1:0]          owner,
  output logic [CNT_W-1:0]                    job_cnt,
  input  logic                                err_clr,
  output logic                                err_timeout
);

  localparam int OWN_W = $clog2(NUM_REQ);
  localparam int WC_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [OWN_W-1:0]    r_rr_ptr;
  logic [OWN_W-1:0]    r_owner;
  logic                r_w_sent;
  logic                r_ctx_sent;
  logic [WC_W-1:0]     r_wait_cnt;
  logic [CNT_W-1:0]    r_job_cnt;
  logic                r_err;
  logic [63:0][31:0]   r_w_buf;
  logic [7:0][31:0]    r_ctx_buf;

  logic                w_gnt_any;
  logic [OWN_W-1:0]    w_gnt_idx;
  logic [NUM_REQ-1:0]  w_gnt_oh;
  logic [OWN_W-1:0]    w_owner_inc;
  logic                w_accept;
  logic                w_w_hs;
  logic                w_ctx_hs;
  logic                w_issue_done;
  logic                w_job_done;

  // Search order starts at rr_ptr; iterating backwards lets the nearest lane win.
  always_comb begin
    int v_idx;
    v_idx     = 0;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_gnt_oh  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      v_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (req_vld[v_idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = OWN_W'(v_idx);
      end
    end
    if (w_gnt_any) w_gnt_oh[w_gnt_idx] = 1'b1;
  end

  assign w_owner_inc  = (r_owner == OWN_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
  assign w_accept     = (r_state == ST_IDLE) & w_gnt_any;
  assign w_w_hs       = (r_state == ST_ISSUE) & ~r_w_sent & cmp_w_rdy;
  assign w_ctx_hs     = (r_state == ST_ISSUE) & ~r_ctx_sent & cmp_ctx_rdy;
  assign w_issue_done = (r_state == ST_ISSUE) & (r_w_sent | w_w_hs) & (r_ctx_sent | w_ctx_hs);
  assign w_job_done   = (r_state == ST_WAIT) & cmp_out_vld & rsp_rdy[r_owner];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_rdy     = '0;
    cmp_w_vld   = 1'b0;
    cmp_ctx_vld = 1'b0;
    cmp_w       = '0;
    cmp_ctx     = '0;
    rsp_vld     = '0;
    rsp_ctx     = '0;
    cmp_out_rdy = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_rdy = w_gnt_oh;
        if (w_gnt_any) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        cmp_w_vld   = ~r_w_sent;
        cmp_ctx_vld = ~r_ctx_sent;
        cmp_w       = r_w_buf;
        cmp_ctx     = r_ctx_buf;
        if (w_issue_done) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // Result path is a pure pass-through so the owner's back-pressure reaches the compressor.
        rsp_vld[r_owner] = cmp_out_vld;
        rsp_ctx          = cmp_out_ctx;
        cmp_out_rdy      = rsp_rdy[r_owner];
        if (w_job_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_w_sent   <= 1'b0;
      r_ctx_sent <= 1'b0;
      r_wait_cnt <= '0;
      r_job_cnt  <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) r_owner <= w_gnt_idx;

      if (w_issue_done) begin
        r_w_sent   <= 1'b0;
        r_ctx_sent <= 1'b0;
      end else begin
        if (w_w_hs)   r_w_sent   <= 1'b1;
        if (w_ctx_hs) r_ctx_sent <= 1'b1;
      end

      if (w_job_done) begin
        r_job_cnt <= r_job_cnt + 1'b1;
        r_rr_ptr  <= w_owner_inc;
      end

      // Counter parks at TIMEOUT so the flag fires once per job and err_clr sticks.
      if (r_state == ST_WAIT) begin
        if (r_wait_cnt != WC_W'(TIMEOUT)) r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end

      if ((r_state == ST_WAIT) && (r_wait_cnt == WC_W'(TIMEOUT - 1))) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_w_buf   <= req_w[w_gnt_idx];
      r_ctx_buf <= req_ctx[w_gnt_idx];
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign owner       = r_owner;
  assign job_cnt     = r_job_cnt;
  assign err_timeout = r_err;

endmodule

`default_nettype wire

// File: tb/tb_msa_scheduler.sv
// ============================================================================
// Module   : tb_msa_scheduler
// Purpose  : Randomized bench for msa_scheduler with a lane/compressor model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_msa_scheduler;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 256;
  localparam int CNT_W   = 16;
  localparam int P_IDLE  = 0;
  localparam int P_ISSUE = 1;
  localparam int P_WAIT  = 2;

  typedef logic [7:0][31:0]  ctx_t;
  typedef logic [63:0][31:0] w_t;

  logic                           clk;
  logic                           rst_n;
  logic [NUM_REQ-1:0]             req_vld, req_rdy, rsp_vld, rsp_rdy;
  logic [NUM_REQ-1:0][63:0][31:0] req_w;
  logic [NUM_REQ-1:0][7:0][31:0]  req_ctx;
  ctx_t                           rsp_ctx, cmp_ctx, cmp_out_ctx;
  w_t                             cmp_w;
  logic                           cmp_w_vld, cmp_w_rdy, cmp_ctx_vld, cmp_ctx_rdy;
  logic                           cmp_out_vld, cmp_out_rdy, busy, err_clr, err_timeout;
  logic [1:0]                     owner;
  logic [CNT_W-1:0]               job_cnt;

  msa_scheduler #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_w(req_w), .req_ctx(req_ctx),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_ctx(rsp_ctx),
    .cmp_w_vld(cmp_w_vld), .cmp_w_rdy(cmp_w_rdy), .cmp_w(cmp_w),
    .cmp_ctx_vld(cmp_ctx_vld), .cmp_ctx_rdy(cmp_ctx_rdy), .cmp_ctx(cmp_ctx),
    .cmp_out_vld(cmp_out_vld), .cmp_out_rdy(cmp_out_rdy), .cmp_out_ctx(cmp_out_ctx),
    .busy(busy), .owner(owner), .job_cnt(job_cnt),
    .err_clr(err_clr), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lane, scheduler and compressor reference state
  bit          lane_pend[NUM_REQ];
  w_t          lane_w[NUM_REQ];
  ctx_t        lane_ctx[NUM_REQ];
  int          lane_refill[NUM_REQ];
  int          phase, m_rr, m_owner, m_wait;
  int unsigned m_cnt;
  bit          m_err, m_w_done, m_ctx_done;
  int          n_w, n_ctx;
  w_t          job_w;
  ctx_t        job_ctx;
  int          gnt_log[$];
  bit          cm_got_w, cm_got_ctx;
  w_t          cm_w;
  ctx_t        cm_ctx;
  int          tw, tc, to, tr;
  int          k_w_dly, k_ctx_dly, k_out_dly, k_rsp_dly;
  bit          k_err_clr;

  function automatic ctx_t rnd_ctx();
    ctx_t c;
    for (int k = 0; k < 8; k++) c[k] = $urandom;
    return c;
  endfunction

  function automatic w_t rnd_w();
    w_t w;
    for (int k = 0; k < 64; k++) w[k] = $urandom;
    return w;
  endfunction

  function automatic ctx_t fold_w(input w_t w);
    ctx_t r;
    r = '0;
    for (int k = 0; k < 64; k++) r[k%8] = {r[k%8][30:0], r[k%8][31]} ^ w[k];
    return r;
  endfunction

  // Stand-in for the compression function: any deterministic mix of w and ctx
  function automatic ctx_t comp_f(input w_t w, input ctx_t c);
    ctx_t f, o;
    f = fold_w(w);
    for (int k = 0; k < 8; k++) o[k] = c[k] + f[k] + 32'h9e37_79b9;
    return o;
  endfunction

  function automatic int exp_grant();
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (m_rr + k) % NUM_REQ;
      if (lane_pend[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit any_pend();
    for (int i = 0; i < NUM_REQ; i++) if (lane_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic apply_inputs();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_vld[i] = lane_pend[i];
      req_w[i]   = lane_w[i];
      req_ctx[i] = lane_ctx[i];
      rsp_rdy[i] = (i == m_owner) ? (tr == 0) : 1'($urandom % 2);
    end
    cmp_w_rdy   = !cm_got_w && (tw == 0);
    cmp_ctx_rdy = !cm_got_ctx && (tc == 0);
    cmp_out_vld = cm_got_w && cm_got_ctx && (to == 0);
    cmp_out_ctx = (cm_got_w && cm_got_ctx) ? comp_f(cm_w, cm_ctx) : rnd_ctx();
    err_clr     = k_err_clr;
  endtask

  task automatic new_job(input int i);
    lane_w[i]   = rnd_w();
    lane_ctx[i] = rnd_ctx();
  endtask

  task automatic cycle();
    int g;
    logic [NUM_REQ-1:0] exp_rr, exp_rsp;
    bit whs, chs, ohs;
    w_t w_seen;
    ctx_t c_seen;
    g = (phase == P_IDLE) ? exp_grant() : -1;
    exp_rr = '0;
    if (g >= 0) exp_rr[g] = 1'b1;
    exp_rsp = '0;
    if (phase == P_WAIT && cmp_out_vld) exp_rsp[m_owner] = 1'b1;
    chk("req_rdy", 256'(req_rdy), 256'(exp_rr));
    chk("busy", busy, phase != P_IDLE);
    chk("cmp_w_vld", cmp_w_vld, phase == P_ISSUE && !m_w_done);
    chk("cmp_ctx_vld", cmp_ctx_vld, phase == P_ISSUE && !m_ctx_done);
    chk("rsp_vld", 256'(rsp_vld), 256'(exp_rsp));
    chk("rsp_ctx", rsp_ctx, (phase == P_WAIT) ? cmp_out_ctx : '0);
    chk("cmp_out_rdy", cmp_out_rdy, (phase == P_WAIT) ? rsp_rdy[m_owner] : 1'b0);
    chk("job_cnt", job_cnt, m_cnt[CNT_W-1:0]);
    chk("err_timeout", err_timeout, m_err);
    if (phase != P_IDLE) chk("owner", owner, 256'(m_owner));
    whs = (phase == P_ISSUE) && !m_w_done && cmp_w_rdy;
    chs = (phase == P_ISSUE) && !m_ctx_done && cmp_ctx_rdy;
    ohs = (phase == P_WAIT) && cmp_out_vld && rsp_rdy[m_owner];
    if (whs) chk("cmp_w_data", fold_w(cmp_w), fold_w(job_w));
    if (chs) chk("cmp_ctx_data", cmp_ctx, job_ctx);
    if (ohs) chk("rsp_ctx_result", rsp_ctx, comp_f(job_w, job_ctx));
    n_w   += int'(cmp_w_vld & cmp_w_rdy);
    n_ctx += int'(cmp_ctx_vld & cmp_ctx_rdy);
    w_seen = cmp_w;
    c_seen = cmp_ctx;
    @(posedge clk);
    #1;
    if (phase == P_WAIT && m_wait == TIMEOUT - 1) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    m_wait = (phase == P_WAIT) ? m_wait + 1 : 0;
    if (phase == P_ISSUE) begin
      if (tw > 0) tw--;
      if (tc > 0) tc--;
    end
    if (cm_got_w && cm_got_ctx && to > 0) to--;
    if (phase == P_WAIT && cmp_out_vld && tr > 0) tr--;
    case (phase)
      P_IDLE: if (g >= 0) begin
        gnt_log.push_back(g);
        m_owner = g;
        job_w   = lane_w[g];
        job_ctx = lane_ctx[g];
        n_w = 0; n_ctx = 0; m_w_done = 0; m_ctx_done = 0;
        tw = k_w_dly; tc = k_ctx_dly; to = k_out_dly; tr = k_rsp_dly;
        if (lane_refill[g] > 0) begin
          lane_refill[g]--;
          new_job(g);
        end else begin
          lane_pend[g] = 1'b0;
        end
        phase = P_ISSUE;
      end
      P_ISSUE: begin
        if (whs) begin m_w_done = 1; cm_got_w = 1; cm_w = w_seen; end
        if (chs) begin m_ctx_done = 1; cm_got_ctx = 1; cm_ctx = c_seen; end
        if (m_w_done && m_ctx_done) begin
          phase = P_WAIT; m_w_done = 0; m_ctx_done = 0;
        end
      end
      default: if (ohs) begin
        chk("w_handshakes", 256'(n_w), 256'(1));
        chk("ctx_handshakes", 256'(n_ctx), 256'(1));
        m_cnt++;
        m_rr = (m_owner + 1) % NUM_REQ;
        phase = P_IDLE;
        cm_got_w = 0; cm_got_ctx = 0;
      end
    endcase
    apply_inputs();
    #1;
  endtask

  task automatic drain(input int max);
    int c;
    c = 0;
    while (!(phase == P_IDLE && !any_pend()) && c < max) begin
      cycle();
      c++;
    end
    if (!(phase == P_IDLE && !any_pend())) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_bound: jobs still open after %0d cycles", c);
    end
  endtask

  task automatic run_jobs(input logic [NUM_REQ-1:0] mask, input int per_lane, input int max);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (mask[i]) begin
        lane_pend[i]   = 1'b1;
        lane_refill[i] = per_lane - 1;
        new_job(i);
      end
    end
    apply_inputs();
    #1;
    drain(max);
  endtask

  task automatic do_reset();
    for (int i = 0; i < NUM_REQ; i++) lane_pend[i] = 1'b0;
    apply_inputs();
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_req_rdy", 256'(req_rdy), '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmp_w_vld", cmp_w_vld, 1'b0);
    chk("rst_cmp_ctx_vld", cmp_ctx_vld, 1'b0);
    chk("rst_rsp_vld", 256'(rsp_vld), '0);
    chk("rst_rsp_ctx", rsp_ctx, '0);
    chk("rst_cmp_out_rdy", cmp_out_rdy, 1'b0);
    chk("rst_job_cnt", job_cnt, '0);
    chk("rst_err", err_timeout, 1'b0);
    chk("rst_owner", owner, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    phase = P_IDLE; m_rr = 0; m_owner = 0; m_wait = 0; m_cnt = 0; m_err = 0;
    m_w_done = 0; m_ctx_done = 0; cm_got_w = 0; cm_got_ctx = 0;
    tw = 0; tc = 0; to = 0; tr = 0;
    apply_inputs();
    #1;
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      lane_pend[i] = 0; lane_refill[i] = 0; new_job(i);
    end
    k_w_dly = 0; k_ctx_dly = 0; k_out_dly = 0; k_rsp_dly = 0; k_err_clr = 0;
    m_owner = 0; tw = 0; tc = 0; to = 0; tr = 0; cm_got_w = 0; cm_got_ctx = 0;
    #3;
    do_reset();

    // Single job on lane 2, compressor always ready
    run_jobs(4'b0100, 1, 100);
    chk("t1_job_cnt", job_cnt, 1);
    cycle();

    // All lanes requesting continuously from reset
    do_reset();
    gnt_log.delete();
    run_jobs(4'b1111, 2, 400);
    chk("t2_njobs", 256'(gnt_log.size()), 256'(8));
    for (int k = 0; k < gnt_log.size() && k < 8; k++) chk("t2_order", 256'(gnt_log[k]), 256'(k % 4));
    chk("t2_job_cnt", job_cnt, 8);

    // Skewed compressor handshake orderings
    k_w_dly = 0; k_ctx_dly = 5; run_jobs(4'b0010, 1, 100);
    k_w_dly = 5; k_ctx_dly = 0; run_jobs(4'b0010, 1, 100);
    k_w_dly = 3; k_ctx_dly = 3; run_jobs(4'b0010, 1, 100);
    k_w_dly = 0; k_ctx_dly = 0;

    // Owner back-pressure while another lane waits
    k_out_dly = 2; k_rsp_dly = 10;
    run_jobs(4'b1001, 1, 200);
    k_out_dly = 0; k_rsp_dly = 0;

    // Watchdog: result withheld beyond TIMEOUT
    k_out_dly = 300;
    run_jobs(4'b0001, 1, 1000);
    chk("t5_err_set", err_timeout, 1'b1);
    k_err_clr = 1; apply_inputs(); #1;
    cycle();
    chk("t5_err_clr", err_timeout, 1'b0);
    run_jobs(4'b0100, 1, 1000);
    chk("t5_err_held_clr", err_timeout, 1'b0);
    k_err_clr = 0; k_out_dly = 0;

    // Randomized mix
    repeat (25) begin
      k_w_dly   = $urandom_range(0, 4);
      k_ctx_dly = $urandom_range(0, 4);
      k_out_dly = $urandom_range(0, 6);
      k_rsp_dly = $urandom_range(0, 4);
      run_jobs(4'($urandom_range(1, 15)), $urandom_range(1, 2), 2000);
    end
    k_w_dly = 0; k_ctx_dly = 0; k_out_dly = 0; k_rsp_dly = 0;

    // Reset during WAIT abandons the job and restarts arbitration at lane 0
    k_out_dly = 50;
    lane_pend[2] = 1; lane_refill[2] = 0; new_job(2);
    apply_inputs(); #1;
    repeat (10) cycle();
    chk("t6_in_wait", busy, 1'b1);
    do_reset();
    k_out_dly = 0;
    gnt_log.delete();
    run_jobs(4'b1111, 1, 200);
    chk("t6_njobs", 256'(gnt_log.size()), 256'(4));
    for (int k = 0; k < gnt_log.size() && k < 4; k++) chk("t6_order", 256'(gnt_log[k]), 256'(k));
    do_reset();
    run_jobs(4'b0100, 1, 100);
    chk("t6_t1_job_cnt", job_cnt, 1);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
